// File: rtl/axi_read_master_mo.sv
// AXI3 read master with multiple outstanding bursts.
// In-order R tracking by {ID, len} FIFO; buffered data output.
module axi_read_master_mo #(
  parameter int   ADDR_W    = 32,
  parameter int   DATA_W    = 32,
  parameter int   ID_W      = 4,
  parameter logic MASTER_ID = 1'b1,
  parameter int   MAX_OUT   = 4,
  localparam int  PW        = $clog2(MAX_OUT),
  localparam int  OW        = PW + 1
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic [2:0]        req_size,
  input  logic [1:0]        req_burst,
  input  logic [1:0]        req_lock,
  input  logic [3:0]        req_cache,
  input  logic [2:0]        req_prot,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [3:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic [1:0]        ARLOCK,
  output logic [3:0]        ARCACHE,
  output logic [2:0]        ARPROT,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [1:0]        dout_resp,
  output logic              dout_last,
  output logic [ID_W-1:0]   dout_id,
  output logic [OW-1:0]     outstanding,
  output logic              err_id,
  output logic              err_last,
  output logic              err_resp,
  input  logic              err_clear
);

  typedef enum logic {AR_IDLE, AR_VALID} ar_state_t;

  localparam logic [ID_W-2:0] SEQ_ONE = 1;

  ar_state_t           r_state;
  logic [ID_W-2:0]     r_seq;
  logic [ID_W-1:0]     r_arid;
  logic [ADDR_W-1:0]   r_araddr;
  logic [3:0]          r_arlen;
  logic [2:0]          r_arsize;
  logic [1:0]          r_arburst;
  logic [1:0]          r_arlock;
  logic [3:0]          r_arcache;
  logic [2:0]          r_arprot;
  logic                r_arvalid;
  logic [ID_W+3:0]     r_fifo [MAX_OUT];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [OW-1:0]       r_out;
  logic [3:0]          r_beat_cnt;
  logic                r_dvalid;
  logic [DATA_W-1:0]   r_ddata;
  logic [1:0]          r_dresp;
  logic                r_dlast;
  logic [ID_W-1:0]     r_did;
  logic                r_err_id;
  logic                r_err_last;
  logic                r_err_resp;

  logic [ID_W-2:0]     w_seq_nxt;
  logic                w_req_hs;
  logic                w_r_hs;
  logic [ID_W+3:0]     w_head;
  logic [ID_W-1:0]     w_head_id;
  logic [3:0]          w_head_len;
  logic                w_beat_last;
  logic                w_burst_end;

  assign w_seq_nxt   = r_seq + SEQ_ONE;
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_head_id   = w_head[ID_W+3:4];
  assign w_head_len  = w_head[3:0];
  assign w_beat_last = (r_beat_cnt == w_head_len);

  assign req_ready = !ARESET
                  && (r_state == AR_IDLE || ARREADY)
                  && (r_out < OW'(MAX_OUT));
  assign w_req_hs  = req_valid && req_ready;

  // FIFO occupancy equals the outstanding count, so it doubles as "empty".
  assign RREADY      = !ARESET && (r_out != '0)
                    && (!r_dvalid || dout_ready);
  assign w_r_hs      = RVALID && RREADY;
  assign w_burst_end = w_r_hs && (w_beat_last || RLAST);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= AR_IDLE;
      r_arvalid <= 1'b0;
      r_seq     <= '0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_arlock  <= '0;
      r_arcache <= '0;
      r_arprot  <= '0;
    end else if (w_req_hs) begin
      r_state   <= AR_VALID;
      r_arvalid <= 1'b1;
      r_seq     <= w_seq_nxt;
      r_arid    <= {MASTER_ID, w_seq_nxt};
      r_araddr  <= req_addr;
      r_arlen   <= req_len;
      r_arsize  <= req_size;
      r_arburst <= req_burst;
      r_arlock  <= req_lock;
      r_arcache <= req_cache;
      r_arprot  <= req_prot;
    end else if (r_state == AR_VALID && ARREADY) begin
      r_state   <= AR_IDLE;
      r_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_req_hs)
      r_fifo[r_wr_ptr] <= {MASTER_ID, w_seq_nxt, req_len};
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_out      <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_req_hs)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_burst_end) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_beat_cnt <= '0;
      end else if (w_r_hs) begin
        r_beat_cnt <= r_beat_cnt + 4'd1;
      end
      if (w_req_hs && !w_burst_end)
        r_out <= r_out + OW'(1);
      else if (!w_req_hs && w_burst_end)
        r_out <= r_out - OW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_dvalid <= 1'b0;
      r_ddata  <= '0;
      r_dresp  <= '0;
      r_dlast  <= 1'b0;
      r_did    <= '0;
    end else if (w_r_hs) begin
      r_dvalid <= 1'b1;
      r_ddata  <= RDATA;
      r_dresp  <= RRESP;
      r_dlast  <= w_beat_last;
      r_did    <= RID;
    end else if (dout_ready) begin
      r_dvalid <= 1'b0;
    end
  end

  // A fresh error in the clearing cycle survives the clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_err_id   <= 1'b0;
      r_err_last <= 1'b0;
      r_err_resp <= 1'b0;
    end else begin
      r_err_id   <= (r_err_id && !err_clear)
                 || (w_r_hs && (RID != w_head_id));
      r_err_last <= (r_err_last && !err_clear)
                 || (w_r_hs && (RLAST != w_beat_last));
      r_err_resp <= (r_err_resp && !err_clear)
                 || (w_r_hs && RRESP[1]);
    end
  end

  assign ARID        = r_arid;
  assign ARADDR      = r_araddr;
  assign ARLEN       = r_arlen;
  assign ARSIZE      = r_arsize;
  assign ARBURST     = r_arburst;
  assign ARLOCK      = r_arlock;
  assign ARCACHE     = r_arcache;
  assign ARPROT      = r_arprot;
  assign ARVALID     = r_arvalid;
  assign dout_valid  = r_dvalid;
  assign dout_data   = r_ddata;
  assign dout_resp   = r_dresp;
  assign dout_last   = r_dlast;
  assign dout_id     = r_did;
  assign outstanding = r_out;
  assign err_id      = r_err_id;
  assign err_last    = r_err_last;
  assign err_resp    = r_err_resp;

endmodule

// File: tb/tb_axi_read_master_mo.sv
// Bench for axi_read_master_mo: AR and dout scoreboards
// filled at handshake time, checked by negedge monitors.
module tb_axi_read_master_mo;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [2:0]  req_size = '0;
  logic [1:0]  req_burst = '0;
  logic [1:0]  req_lock = '0;
  logic [3:0]  req_cache = '0;
  logic [2:0]  req_prot = '0;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [1:0]  ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY = 1'b1;
  logic [3:0]  RID = '0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RLAST = 1'b0;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [31:0] dout_data;
  logic [1:0]  dout_resp;
  logic        dout_last;
  logic [3:0]  dout_id;
  logic [2:0]  outstanding;
  logic        err_id, err_last, err_resp;
  logic        err_clear = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_dout  = 0;
  logic [2:0]  tb_seq = '0;
  logic [53:0] ar_q[$];
  logic [38:0] dout_q[$];
  logic [53:0] m_ar_got, m_ar_exp;
  logic [38:0] m_d_got, m_d_exp;

  always #5 ACLK = ~ACLK;

  axi_read_master_mo dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .req_size(req_size), .req_burst(req_burst),
    .req_lock(req_lock), .req_cache(req_cache),
    .req_prot(req_prot),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
    .ARPROT(ARPROT), .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_resp(dout_resp),
    .dout_last(dout_last), .dout_id(dout_id),
    .outstanding(outstanding),
    .err_id(err_id), .err_last(err_last),
    .err_resp(err_resp), .err_clear(err_clear)
  );

  // Scoreboard monitors: handshakes seen at negedge complete on the next posedge.
  always @(negedge ACLK) begin
    if (ARVALID && ARREADY && !ARESET) begin
      m_ar_got = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
                  ARLOCK, ARCACHE, ARPROT};
      n_tests++;
      if (ar_q.size() == 0) begin
        n_fail++;
        $display("FAIL ar_unexpected got=%h", m_ar_got);
      end else begin
        m_ar_exp = ar_q.pop_front();
        if (m_ar_got !== m_ar_exp) begin
          n_fail++;
          $display("FAIL ar_payload got=%h exp=%h",
                   m_ar_got, m_ar_exp);
        end
      end
    end
    if (dout_valid && dout_ready && !ARESET) begin
      m_d_got = {dout_id, dout_data, dout_resp, dout_last};
      n_dout++;
      n_tests++;
      if (dout_q.size() == 0) begin
        n_fail++;
        $display("FAIL dout_unexpected got=%h", m_d_got);
      end else begin
        m_d_exp = dout_q.pop_front();
        if (m_d_got !== m_d_exp) begin
          n_fail++;
          $display("FAIL dout_beat got=%h exp=%h",
                   m_d_got, m_d_exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic do_req(input logic [31:0] a,
                        input logic [3:0] l,
                        input logic [1:0] b);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    req_size  = 3'd2;
    req_burst = b;
    req_lock  = a[13:12];
    req_cache = a[7:4];
    req_prot  = a[10:8];
    @(negedge ACLK);
    while (!req_ready && t < 40) begin
      @(posedge ACLK);
      #1;
      @(negedge ACLK);
      t++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout addr=%h", a);
    end else begin
      tb_seq = tb_seq + 3'd1;
      ar_q.push_back({1'b1, tb_seq, a, l, 3'd2, b,
                      a[13:12], a[7:4], a[10:8]});
    end
    @(posedge ACLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [3:0] id,
                           input logic [31:0] d,
                           input logic [1:0] resp,
                           input logic rl,
                           input logic exp_last);
    int t;
    t = 0;
    RVALID = 1'b1;
    RID    = id;
    RDATA  = d;
    RRESP  = resp;
    RLAST  = rl;
    @(negedge ACLK);
    while (!RREADY && t < 40) begin
      @(posedge ACLK);
      #1;
      @(negedge ACLK);
      t++;
    end
    if (!RREADY) begin
      n_tests++;
      n_fail++;
      $display("FAIL rready_timeout data=%h", d);
    end else begin
      dout_q.push_back({id, d, resp, exp_last});
    end
    @(posedge ACLK);
    #1;
    RVALID = 1'b0;
    RLAST  = 1'b0;
  endtask

  task automatic test_reset;
    logic [55:0] st;
    ARESET = 1'b1;
    idle(2);
    @(negedge ACLK);
    st = {ARVALID, RREADY, dout_valid, req_ready,
          outstanding, err_id, err_last, err_resp,
          ARID, ARADDR, dout_data};
    n_tests++;
    if (st !== 56'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", st);
    end
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    n_tests++;
    if ({req_ready, outstanding} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=1000",
               {req_ready, outstanding});
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_single;
    logic [3:0] id;
    int n0;
    n0 = n_dout;
    do_req(32'h100, 4'd3, 2'd1);
    id = {1'b1, tb_seq};
    @(negedge ACLK);
    n_tests++;
    if ({ARVALID, outstanding} !== 4'b1001) begin
      n_fail++;
      $display("FAIL single_issue got=%b exp=1001",
               {ARVALID, outstanding});
    end
    @(posedge ACLK);
    #1;
    for (int i = 0; i < 4; i++)
      send_beat(id, 32'hA0 + i, 2'b00, i == 3, i == 3);
    idle(2);
    @(negedge ACLK);
    n_tests++;
    if ({outstanding, err_id, err_last, err_resp} !== 6'b0
        || n_dout - n0 != 4) begin
      n_fail++;
      $display("FAIL single_done got=%b beats=%0d exp=0 beats=4",
               {outstanding, err_id, err_last, err_resp},
               n_dout - n0);
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_outstanding;
    logic [3:0] ids [5];
    for (int i = 0; i < 4; i++) begin
      do_req(32'h1000 + 32'(i) * 32'h40,
             (i == 1) ? 4'd1 : 4'd0, 2'd1);
      ids[i] = {1'b1, tb_seq};
    end
    @(negedge ACLK);
    n_tests++;
    if ({req_ready, outstanding} !== 4'b0100) begin
      n_fail++;
      $display("FAIL out_limit got=%b exp=0100",
               {req_ready, outstanding});
    end
    @(posedge ACLK);
    #1;
    fork
      do_req(32'h2000, 4'd0, 2'd1);
      begin
        @(negedge ACLK);
        n_tests++;
        if (req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL out_blocked got=%b exp=0", req_ready);
        end
        @(posedge ACLK);
        #1;
        send_beat(ids[0], 32'h1111, 2'b00, 1'b1, 1'b1);
        @(negedge ACLK);
        n_tests++;
        if ({req_ready, outstanding} !== 4'b1011) begin
          n_fail++;
          $display("FAIL out_reopen got=%b exp=1011",
                   {req_ready, outstanding});
        end
        @(posedge ACLK);
        #1;
      end
    join
    ids[4] = {1'b1, tb_seq};
    send_beat(ids[1], 32'h2220, 2'b00, 1'b0, 1'b0);
    send_beat(ids[1], 32'h2221, 2'b00, 1'b1, 1'b1);
    for (int i = 2; i < 5; i++)
      send_beat(ids[i], 32'h3330 + i, 2'b00, 1'b1, 1'b1);
    idle(2);
    @(negedge ACLK);
    n_tests++;
    if ({outstanding, err_id, err_last, err_resp} !== 6'b0) begin
      n_fail++;
      $display("FAIL out_drain got=%b exp=0",
               {outstanding, err_id, err_last, err_resp});
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_ar_backpressure;
    logic [3:0] ida, idb;
    ARREADY = 1'b0;
    do_req(32'h200, 4'd1, 2'd2);
    ida = {1'b1, tb_seq};
    fork
      do_req(32'h300, 4'd0, 2'd1);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge ACLK);
          n_tests++;
          if ({ARVALID, ARADDR, req_ready} !== {1'b1, 32'h200, 1'b0}) begin
            n_fail++;
            $display("FAIL arbp_hold%0d got=%b/%h/%b exp=1/200/0",
                     i, ARVALID, ARADDR, req_ready);
          end
          @(posedge ACLK);
          #1;
        end
        ARREADY = 1'b1;
        @(negedge ACLK);
        n_tests++;
        if (req_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL arbp_accept got=%b exp=1", req_ready);
        end
        @(posedge ACLK);
        #1;
      end
    join
    idb = {1'b1, tb_seq};
    send_beat(ida, 32'h5550, 2'b00, 1'b0, 1'b0);
    send_beat(ida, 32'h5551, 2'b00, 1'b1, 1'b1);
    send_beat(idb, 32'h6660, 2'b01, 1'b1, 1'b1);
    idle(2);
    @(negedge ACLK);
    n_tests++;
    if ({outstanding, ARVALID} !== 4'b0) begin
      n_fail++;
      $display("FAIL arbp_done got=%b exp=0",
               {outstanding, ARVALID});
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_dout_backpressure;
    logic [3:0] id;
    int n0;
    n0 = n_dout;
    do_req(32'h400, 4'd3, 2'd1);
    id = {1'b1, tb_seq};
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          dout_ready = ~dout_ready;
          @(posedge ACLK);
          #1;
        end
        dout_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 14; i++) begin
          @(negedge ACLK);
          if (dout_valid && !dout_ready) begin
            n_tests++;
            if (RREADY !== 1'b0) begin
              n_fail++;
              $display("FAIL dbp_rready got=%b exp=0", RREADY);
            end
          end
          @(posedge ACLK);
          #1;
        end
      end
      for (int i = 0; i < 4; i++)
        send_beat(id, 32'hC0DE0 + i, 2'b00, i == 3, i == 3);
    join
    idle(2);
    @(negedge ACLK);
    n_tests++;
    if (n_dout - n0 != 4 || dout_q.size() != 0) begin
      n_fail++;
      $display("FAIL dbp_count got=%0d pend=%0d exp=4 pend=0",
               n_dout - n0, dout_q.size());
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_errors;
    logic [3:0] ida, idb, idc;
    do_req(32'h500, 4'd3, 2'd1);
    ida = {1'b1, tb_seq};
    do_req(32'h600, 4'd1, 2'd1);
    idb = {1'b1, tb_seq};
    send_beat(ida, 32'hE0, 2'b00, 1'b0, 1'b0);
    send_beat(ida, 32'hE1, 2'b00, 1'b1, 1'b0);
    @(negedge ACLK);
    n_tests++;
    if ({err_id, err_last, err_resp, outstanding} !== 6'b010001) begin
      n_fail++;
      $display("FAIL err_last got=%b exp=010001",
               {err_id, err_last, err_resp, outstanding});
    end
    @(posedge ACLK);
    #1;
    send_beat(idb, 32'hE2, 2'b00, 1'b0, 1'b0);
    send_beat(idb, 32'hE3, 2'b00, 1'b1, 1'b1);
    @(negedge ACLK);
    n_tests++;
    if ({err_id, err_last, err_resp, outstanding} !== 6'b010000) begin
      n_fail++;
      $display("FAIL err_next_burst got=%b exp=010000",
               {err_id, err_last, err_resp, outstanding});
    end
    @(posedge ACLK);
    #1;
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    @(negedge ACLK);
    n_tests++;
    if ({err_id, err_last, err_resp} !== 3'b000) begin
      n_fail++;
      $display("FAIL err_clear1 got=%b exp=000",
               {err_id, err_last, err_resp});
    end
    @(posedge ACLK);
    #1;
    do_req(32'h700, 4'd0, 2'd1);
    idc = {1'b1, tb_seq};
    send_beat(idc ^ 4'h1, 32'hE4, 2'b00, 1'b1, 1'b1);
    @(negedge ACLK);
    n_tests++;
    if ({err_id, err_last, err_resp} !== 3'b100) begin
      n_fail++;
      $display("FAIL err_id got=%b exp=100",
               {err_id, err_last, err_resp});
    end
    @(posedge ACLK);
    #1;
    do_req(32'h800, 4'd0, 2'd1);
    send_beat({1'b1, tb_seq}, 32'hE5, 2'b10, 1'b1, 1'b1);
    @(negedge ACLK);
    n_tests++;
    if ({err_id, err_last, err_resp} !== 3'b101) begin
      n_fail++;
      $display("FAIL err_resp got=%b exp=101",
               {err_id, err_last, err_resp});
    end
    @(posedge ACLK);
    #1;
    err_clear = 1'b1;
    do_req(32'h900, 4'd0, 2'd1);
    send_beat({1'b1, tb_seq}, 32'hE6, 2'b11, 1'b1, 1'b1);
    err_clear = 1'b0;
    @(negedge ACLK);
    n_tests++;
    if ({err_id, err_last, err_resp} !== 3'b001) begin
      n_fail++;
      $display("FAIL err_set_wins got=%b exp=001",
               {err_id, err_last, err_resp});
    end
    @(posedge ACLK);
    #1;
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    @(negedge ACLK);
    n_tests++;
    if ({err_id, err_last, err_resp, outstanding} !== 6'b0) begin
      n_fail++;
      $display("FAIL err_clear2 got=%b exp=0",
               {err_id, err_last, err_resp, outstanding});
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset_mid_burst;
    logic [43:0] st;
    do_req(32'hA00, 4'd3, 2'd1);
    idle(1);
    RVALID = 1'b1;
    RID    = {1'b1, tb_seq};
    RDATA  = 32'hDEAD;
    RRESP  = 2'b00;
    RLAST  = 1'b0;
    ARESET = 1'b1;
    idle(1);
    ARESET = 1'b0;
    RVALID = 1'b0;
    tb_seq = '0;
    @(negedge ACLK);
    st = {ARVALID, RREADY, dout_valid, outstanding,
          err_id, err_last, err_resp, ARID, ARADDR};
    n_tests++;
    if (st !== 44'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got=%h exp=0", st);
    end
    @(posedge ACLK);
    #1;
    do_req(32'hB00, 4'd0, 2'd1);
    @(negedge ACLK);
    n_tests++;
    if ({ARVALID, ARID, outstanding} !== 8'b1_1001_001) begin
      n_fail++;
      $display("FAIL rst_fresh_id got=%b exp=11001001",
               {ARVALID, ARID, outstanding});
    end
    @(posedge ACLK);
    #1;
    send_beat(4'h9, 32'hF00D, 2'b00, 1'b1, 1'b1);
    idle(2);
    @(negedge ACLK);
    n_tests++;
    if ({outstanding, err_id, err_last, err_resp} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_fresh_done got=%b exp=0",
               {outstanding, err_id, err_last, err_resp});
    end
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_outstanding();
    test_ar_backpressure();
    test_dout_backpressure();
    test_errors();
    test_reset_mid_burst();
    n_tests++;
    if (ar_q.size() != 0 || dout_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left ar=%0d dout=%0d exp=0",
               ar_q.size(), dout_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
